// File: rtl/debounce4_pkg.sv
// Shared constants, types and helpers for the four-channel debouncer.
package debounce4_pkg;

    localparam int unsigned NUM_CH                  = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef logic [NUM_CH-1:0] ch_vec_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, accepted level
// and a registered pulse on each accepted 0->1 change.
module debounce_ch
    import debounce4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned       CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]   CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic            r_rise;
    logic [CntW-1:0] r_cnt;

    logic            w_stable_d;
    logic            w_rise_d;
    logic [CntW-1:0] w_cnt_d;

    // Next-state: count consecutive cycles that disagree with the accepted level.
    always_comb begin
        w_cnt_d    = '0;
        w_stable_d = r_stable;
        w_rise_d   = 1'b0;
        if (r_sync2 != r_stable) begin
            if (r_cnt == CntMax) begin
                // Held long enough: accept the new level, restart from zero.
                w_stable_d = r_sync2;
                w_rise_d   = r_sync2;
            end else begin
                w_cnt_d = r_cnt + CntW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_raw;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_d;
            r_rise   <= w_rise_d;
            r_cnt    <= w_cnt_d;
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;

endmodule

// File: rtl/debounce4.sv
// Four independent debounce channels with sticky, acknowledgeable requests.
module debounce4
    import debounce4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw0,
    input  logic raw1,
    input  logic raw2,
    input  logic raw3,
    input  logic ack0,
    input  logic ack1,
    input  logic ack2,
    input  logic ack3,
    output logic in0,
    output logic in1,
    output logic in2,
    output logic in3,
    output logic rise0,
    output logic rise1,
    output logic rise2,
    output logic rise3,
    output logic req0,
    output logic req1,
    output logic req2,
    output logic req3,
    output logic any_req
);

    ch_vec_t w_raw;
    ch_vec_t w_ack;
    ch_vec_t w_level;
    ch_vec_t w_rise;
    ch_vec_t r_req;

    assign w_raw = {raw3, raw2, raw1, raw0};
    assign w_ack = {ack3, ack2, ack1, ack0};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (w_raw[g]),
            .o_level(w_level[g]),
            .o_rise (w_rise[g])
        );
    end

    // Sticky requests: a rise sets, an ack clears, and set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= '0;
        end else begin
            r_req <= w_rise | (r_req & ~w_ack);
        end
    end

    assign {in3, in2, in1, in0}         = w_level;
    assign {rise3, rise2, rise1, rise0} = w_rise;
    assign {req3, req2, req1, req0}     = r_req;
    assign any_req                      = |r_req;

endmodule

// File: tb/tb_debounce4.sv
// Bench for debounce4 with DEBOUNCE_CYCLES=4: directed scenarios followed by
// random bouncing, acks and resets, checked every cycle against a window model.
module tb_debounce4;

    localparam int unsigned DC   = 4;
    localparam int          MaxE = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw = '0;
    logic [3:0] ack = '0;
    logic       in0, in1, in2, in3;
    logic       rise0, rise1, rise2, rise3;
    logic       req0, req1, req2, req3;
    logic       any_req;

    always #5 clk = ~clk;

    debounce4 #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw0   (raw[0]),
        .raw1   (raw[1]),
        .raw2   (raw[2]),
        .raw3   (raw[3]),
        .ack0   (ack[0]),
        .ack1   (ack[1]),
        .ack2   (ack[2]),
        .ack3   (ack[3]),
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .in3    (in3),
        .rise0  (rise0),
        .rise1  (rise1),
        .rise2  (rise2),
        .rise3  (rise3),
        .req0   (req0),
        .req1   (req1),
        .req2   (req2),
        .req3   (req3),
        .any_req(any_req)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // History of what the DUT sampled at each rising edge.
    logic [3:0] raw_h [MaxE];
    logic       rst_h [MaxE];
    int         k = -1;

    // Expected outputs after the most recent edge.
    logic [3:0] m_stable = '0;
    logic [3:0] m_rise   = '0;
    logic [3:0] m_req    = '0;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", tag, k, got, exp);
        end
    endtask

    // Synchronized level seen by the channel logic at edge j: the raw value from
    // two edges earlier, unless a reset at either of those edges flushed it.
    function automatic logic samp(input int ch, input int j);
        if (j < 2) return 1'b0;
        if (rst_h[j-2] || rst_h[j-1]) return 1'b0;
        return raw_h[j-2][ch];
    endfunction

    // Accepted level flips at edge k when the last DC synchronized samples, all
    // reset-free, disagree with the currently accepted level.
    task automatic model_edge(input logic [3:0] a, input logic rs);
        logic flip;
        if (rs) begin
            m_stable = '0;
            m_rise   = '0;
            m_req    = '0;
        end else begin
            m_req = m_rise | (m_req & ~a);
            for (int ch = 0; ch < 4; ch++) begin
                flip = 1'b1;
                for (int d = 0; d < int'(DC); d++) begin
                    if ((k - d) < 0) flip = 1'b0;
                    else if (rst_h[k-d] || samp(ch, k - d) == m_stable[ch]) flip = 1'b0;
                end
                m_rise[ch] = flip && !m_stable[ch];
                if (flip) m_stable[ch] = ~m_stable[ch];
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] a, input logic rs);
        @(negedge clk);
        raw = r;
        ack = a;
        rst = rs;
        @(posedge clk);
        k++;
        if (k >= MaxE) begin
            $display("FAIL history: edge budget %0d exceeded", MaxE);
            $fatal(1, "edge budget exceeded");
        end
        raw_h[k] = r;
        rst_h[k] = rs;
        model_edge(a, rs);
        #1;
        check("in",      {in3, in2, in1, in0},         m_stable);
        check("rise",    {rise3, rise2, rise1, rise0}, m_rise);
        check("req",     {req3, req2, req1, req0},     m_req);
        check("any_req", {3'b000, any_req},            {3'b000, |m_req});
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] a;
        logic       rs;

        // Reset with all inputs low.
        repeat (2) step(4'b0000, 4'b0000, 1'b1);

        // Clean press and release on channel 0.
        repeat (12) step(4'b0001, 4'b0000, 1'b0);
        repeat (12) step(4'b0000, 4'b0000, 1'b0);

        // Bounce on channel 1, then a steady hold.
        for (int i = 0; i < 4; i++) repeat (2) step({2'b00, ~i[0], 1'b0}, 4'b0000, 1'b0);
        repeat (12) step(4'b0010, 4'b0000, 1'b0);
        repeat (12) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0011, 1'b0);

        // Ack coinciding with rise2: set must win.
        repeat (12) step(4'b0100, {1'b0, m_rise[2], 2'b00}, 1'b0);
        repeat (12) step(4'b0000, 4'b0000, 1'b0);
        // Ack one cycle after rise2: request clears.
        repeat (12) step(4'b0100, {1'b0, m_req[2] & ~m_rise[2], 2'b00}, 1'b0);
        repeat (12) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b1111, 1'b0);

        // Channels 3 and 0 rising together.
        repeat (12) step(4'b1001, 4'b0000, 1'b0);
        repeat (12) step(4'b0000, 4'b1111, 1'b0);

        // Reset mid-count on channel 2, raw held high across it.
        repeat (4) step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b1);
        repeat (12) step(4'b0100, 4'b0000, 1'b0);
        repeat (12) step(4'b0000, 4'b1111, 1'b0);

        // Random bouncing, acks and occasional resets.
        r = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
                a[b] = ($urandom_range(0, 7) == 0);
            end
            rs = ($urandom_range(0, 199) == 0);
            step(r, a, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
